// File: rtl/clock_pkg.sv
// Shared 7-segment patterns, scan digit positions and capture FSM states.
// Used by both the scan driver and the capture side; pure constants and helpers, no timing.
package clock_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  localparam int POS_SEC_ONES  = 0;
  localparam int POS_SEC_TENS  = 1;
  localparam int POS_MIN_ONES  = 2;
  localparam int POS_MIN_TENS  = 3;
  localparam int POS_HOUR_ONES = 4;
  localparam int POS_HOUR_TENS = 5;

  typedef enum logic [1:0] {HUNT, COLLECT, PUBLISH} cap_state_e;

  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  function automatic logic [2:0] pos_index(input logic [5:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_capture_dec.sv
// Combinational 7-segment pattern to BCD decode; unknown patterns flag bad.
// Zero latency, no flow control.
module seg7_to_bcd
  import clock_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       bad
);

  always_comb begin
    bcd = 4'd0;
    bad = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the multiplexed 7-seg scan bus: sync, debounce, decode, assemble HH:MM:SS frames.
// frame_valid/frame_err one cycle after the completing digit accept; inputs are sampled, no backpressure.
module seg_scan_capture
  import clock_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic       clk_50m,
  input  logic       cr,
  input  logic [6:0] seg,
  input  logic [7:0] pos,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_lost
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [6:0]        seg_m, seg_s, seg_q;
  logic [7:0]        pos_m, pos_s, pos_q;
  logic [SW-1:0]     stab_cnt;
  logic              stab_taken, changed, stable_hit, accept;
  logic [2:0]        acc_idx;
  logic [3:0]        dec_bcd;
  logic              dec_bad;
  cap_state_e        state, state_nxt;
  logic [5:0]        mask;
  logic              frame_bad;
  logic [5:0][3:0]   slot;
  logic              pend_vld, pend_bad;
  logic [2:0]        pend_idx;
  logic [3:0]        pend_bcd;
  logic              wr_vld, wr_bad, mask_full_nxt;
  logic [2:0]        wr_idx;
  logic [3:0]        wr_bcd;
  logic [TW-1:0]     to_cnt;
  logic              timeout_hit, range_ok, publish_ok;
  logic [7:0]        hour_q, minute_q, second_q;

  always_ff @(posedge clk_50m or negedge cr) begin
    if (!cr) begin
      seg_m <= '0; seg_s <= '0; seg_q <= '0;
      pos_m <= '0; pos_s <= '0; pos_q <= '0;
    end else begin
      seg_m <= seg;   seg_s <= seg_m; seg_q <= seg_s;
      pos_m <= pos;   pos_s <= pos_m; pos_q <= pos_s;
    end
  end

  // One accept per stable period: stab_taken blocks re-accept until the bus moves.
  assign changed    = {seg_s, pos_s} != {seg_q, pos_q};
  assign stable_hit = !changed && (stab_cnt == STABLE_MAX) && !stab_taken;
  assign accept     = stable_hit && is_onehot6(pos_s[5:0]);
  assign acc_idx    = pos_index(pos_s[5:0]);

  always_ff @(posedge clk_50m or negedge cr) begin
    if (!cr) begin
      stab_cnt   <= '0;
      stab_taken <= 1'b0;
    end else if (changed) begin
      stab_cnt   <= '0;
      stab_taken <= 1'b0;
    end else begin
      if (stab_cnt != STABLE_MAX) stab_cnt <= stab_cnt + SW'(1);
      if (stable_hit) stab_taken <= 1'b1;
    end
  end

  seg7_to_bcd u_dec (
    .seg (seg_s),
    .bcd (dec_bcd),
    .bad (dec_bad)
  );

  // A digit held over from PUBLISH takes priority; accepts cannot arrive back to back.
  always_comb begin
    wr_vld = 1'b0;
    wr_idx = acc_idx;
    wr_bcd = dec_bcd;
    wr_bad = dec_bad;
    if (state == COLLECT && pend_vld) begin
      wr_vld = 1'b1;
      wr_idx = pend_idx;
      wr_bcd = pend_bcd;
      wr_bad = pend_bad;
    end else if (accept && (state == COLLECT ||
                            (state == HUNT && acc_idx == 3'(POS_SEC_ONES)))) begin
      wr_vld = 1'b1;
    end
  end

  assign mask_full_nxt = (mask | (6'd1 << wr_idx)) == 6'h3F;
  assign timeout_hit   = to_cnt == TIMEOUT_MAX;

  always_ff @(posedge clk_50m or negedge cr) begin
    if (!cr) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (wr_vld) state_nxt = COLLECT;
      COLLECT: begin
        if (wr_vld && mask_full_nxt)    state_nxt = PUBLISH;
        else if (!wr_vld && timeout_hit) state_nxt = HUNT;
      end
      PUBLISH: state_nxt = COLLECT;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk_50m or negedge cr) begin
    if (!cr) begin
      mask      <= '0;
      frame_bad <= 1'b0;
      slot      <= '0;
      pend_vld  <= 1'b0;
      pend_idx  <= '0;
      pend_bcd  <= '0;
      pend_bad  <= 1'b0;
    end else begin
      if (state == PUBLISH || state_nxt == HUNT) begin
        mask      <= '0;
        frame_bad <= 1'b0;
      end else if (wr_vld) begin
        mask[wr_idx] <= 1'b1;
        frame_bad    <= frame_bad | wr_bad;
      end
      if (wr_vld) slot[wr_idx] <= wr_bcd;
      pend_vld <= (state == PUBLISH) && accept;
      if (state == PUBLISH && accept) begin
        pend_idx <= acc_idx;
        pend_bcd <= dec_bcd;
        pend_bad <= dec_bad;
      end
    end
  end

  // link_lost rises together with saturation and stays up until the next accept.
  always_ff @(posedge clk_50m or negedge cr) begin
    if (!cr) begin
      to_cnt    <= '0;
      link_lost <= 1'b1;
    end else if (accept) begin
      to_cnt    <= '0;
      link_lost <= 1'b0;
    end else begin
      if (!timeout_hit) to_cnt <= to_cnt + TW'(1);
      if (to_cnt >= TIMEOUT_MAX - TW'(1)) link_lost <= 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge cr) begin
    if (!cr) begin
      hour_q   <= 8'h00;
      minute_q <= 8'h00;
      second_q <= 8'h00;
    end else if (publish_ok) begin
      hour_q   <= {slot[POS_HOUR_TENS], slot[POS_HOUR_ONES]};
      minute_q <= {slot[POS_MIN_TENS],  slot[POS_MIN_ONES]};
      second_q <= {slot[POS_SEC_TENS],  slot[POS_SEC_ONES]};
    end
  end

  always_comb begin
    range_ok = (slot[POS_SEC_TENS] <= 4'd5) && (slot[POS_MIN_TENS] <= 4'd5) &&
               ({slot[POS_HOUR_TENS], slot[POS_HOUR_ONES]} <= 8'h23) &&
               (slot[POS_SEC_ONES] <= 4'd9) && (slot[POS_MIN_ONES] <= 4'd9) &&
               (slot[POS_HOUR_ONES] <= 4'd9);
    publish_ok  = (state == PUBLISH) && !frame_bad && range_ok;
    frame_valid = publish_ok;
    frame_err   = (state == PUBLISH) && !publish_ok;
    hour   = publish_ok ? {slot[POS_HOUR_TENS], slot[POS_HOUR_ONES]} : hour_q;
    minute = publish_ok ? {slot[POS_MIN_TENS],  slot[POS_MIN_ONES]}  : minute_q;
    second = publish_ok ? {slot[POS_SEC_TENS],  slot[POS_SEC_ONES]}  : second_q;
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: randomized scan traffic against a digit-level frame model.
// Small STABLE/TIMEOUT values keep the run short.
module tb_seg_scan_capture;

  localparam int STB = 4;
  localparam int TMO = 300;

  logic       clk_50m = 1'b0;
  logic       cr = 1'b0;
  logic [6:0] seg = 7'h00;
  logic [7:0] pos = 8'h00;
  logic [7:0] hour, minute, second;
  logic       frame_valid, frame_err, link_lost;

  seg_scan_capture #(.STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_50m     (clk_50m),
    .cr          (cr),
    .seg         (seg),
    .pos         (pos),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .link_lost   (link_lost)
  );

  always #10 clk_50m = ~clk_50m;

  int total = 0;
  int bad   = 0;
  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  // Frame model: digits arrive whole; a frame is sec-ones aligned and closes when all six are seen.
  bit          hunting;
  bit          seen [6];
  int          val [6];
  bit          fbad;
  logic [7:0]  pub_h, pub_m, pub_s;
  logic [24:0] exp_q [$];
  logic [24:0] got_q [$];

  always @(negedge clk_50m) begin
    if (frame_valid) got_q.push_back({1'b1, hour, minute, second});
    if (frame_err)   got_q.push_back({1'b0, hour, minute, second});
  end

  function automatic void model_clear();
    foreach (seen[i]) seen[i] = 1'b0;
    fbad = 1'b0;
  endfunction

  function automatic void model_reset();
    hunting = 1'b1;
    model_clear();
    pub_h = 8'h00; pub_m = 8'h00; pub_s = 8'h00;
  endfunction

  function automatic void model_digit(input logic [7:0] p, input logic [6:0] s);
    int idx, d, h, m, sc;
    if ($countones(p[5:0]) != 1) return;
    idx = 0;
    for (int i = 0; i < 6; i++) if (p[i]) idx = i;
    d = -1;
    for (int k = 0; k < 10; k++) if (seg_tab[k] == s) d = k;
    if (hunting) begin
      if (idx != 0) return;
      hunting = 1'b0;
    end
    seen[idx] = 1'b1;
    val[idx]  = (d < 0) ? 0 : d;
    if (d < 0) fbad = 1'b1;
    for (int i = 0; i < 6; i++) if (!seen[i]) return;
    h  = val[5] * 10 + val[4];
    m  = val[3] * 10 + val[2];
    sc = val[1] * 10 + val[0];
    if (!fbad && h <= 23 && m <= 59 && sc <= 59) begin
      pub_h = {4'(val[5]), 4'(val[4])};
      pub_m = {4'(val[3]), 4'(val[2])};
      pub_s = {4'(val[1]), 4'(val[0])};
      exp_q.push_back({1'b1, pub_h, pub_m, pub_s});
    end else begin
      exp_q.push_back({1'b0, pub_h, pub_m, pub_s});
    end
    model_clear();
  endfunction

  task automatic show(input logic [7:0] p, input logic [6:0] s, input int dwell);
    seg = s;
    pos = p;
    model_digit(p, s);
    repeat (dwell) @(negedge clk_50m);
  endtask

  task automatic scan(input int h, input int m, input int sc, input int lo, input int hi);
    int dg [6];
    dg = '{sc % 10, sc / 10, m % 10, m / 10, h % 10, h / 10};
    for (int i = lo; i <= hi; i++) show(8'(1 << i), seg_tab[dg[i]], int'($urandom_range(8, 16)));
  endtask

  task automatic test_reset();
    cr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_50m);
    total++; if ({hour, minute, second} !== 24'h000000) begin bad++; $display("FAIL reset_time got=%h exp=000000", {hour, minute, second}); end
    total++; if ({frame_valid, frame_err} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {frame_valid, frame_err}); end
    total++; if (link_lost !== 1'b1) begin bad++; $display("FAIL reset_link_lost got=%b exp=1", link_lost); end
    cr = 1'b1;
    @(negedge clk_50m);
  endtask

  task automatic test_scan();
    scan(12, 34, 56, 0, 5);
    scan(12, 34, 56, 0, 5);
    repeat (4) @(negedge clk_50m);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL scan_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL scan_evt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    total++; if ({hour, minute, second} !== 24'h123456) begin bad++; $display("FAIL scan_time got=%h exp=123456", {hour, minute, second}); end
  endtask

  task automatic test_bad_digit();
    scan(12, 34, 56, 0, 1);
    show(8'h04, 7'h00, 12);
    scan(12, 34, 56, 3, 5);
    scan(8, 15, 42, 0, 5);
    repeat (4) @(negedge clk_50m);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL baddig_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL baddig_evt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    total++; if ({hour, minute, second} !== 24'h081542) begin bad++; $display("FAIL baddig_time got=%h exp=081542", {hour, minute, second}); end
  endtask

  task automatic test_range();
    scan(25, 61, 0, 0, 5);
    repeat (4) @(negedge clk_50m);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL range_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL range_evt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    total++; if ({hour, minute, second} !== 24'h081542) begin bad++; $display("FAIL range_hold got=%h exp=081542", {hour, minute, second}); end
  endtask

  task automatic test_glitch();
    scan(19, 7, 33, 0, 2);
    pos = 8'h08;
    for (int i = 0; i < STB - 2; i++) begin
      seg = seg_tab[i];
      @(negedge clk_50m);
    end
    pos = 8'h03;
    seg = seg_tab[8];
    repeat (30) @(negedge clk_50m);
    scan(19, 7, 33, 3, 5);
    repeat (4) @(negedge clk_50m);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL glitch_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL glitch_evt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    total++; if ({hour, minute, second} !== 24'h190733) begin bad++; $display("FAIL glitch_time got=%h exp=190733", {hour, minute, second}); end
  endtask

  task automatic test_link_lost();
    pos = 8'h00;
    seg = 7'h00;
    hunting = 1'b1;
    model_clear();
    repeat (TMO + 20) @(negedge clk_50m);
    total++; if (link_lost !== 1'b1) begin bad++; $display("FAIL link_lost_set got=%b exp=1", link_lost); end
    scan(6, 30, 0, 3, 3);
    total++; if (link_lost !== 1'b0) begin bad++; $display("FAIL link_lost_clear got=%b exp=0", link_lost); end
    scan(6, 30, 0, 4, 5);
    scan(23, 59, 59, 0, 5);
    repeat (4) @(negedge clk_50m);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL link_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL link_evt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    total++; if ({hour, minute, second} !== 24'h235959) begin bad++; $display("FAIL link_time got=%h exp=235959", {hour, minute, second}); end
  endtask

  task automatic test_cr_midframe();
    scan(10, 20, 30, 0, 2);
    cr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_50m);
    total++; if ({hour, minute, second} !== 24'h000000) begin bad++; $display("FAIL cr_time got=%h exp=000000", {hour, minute, second}); end
    total++; if ({frame_valid, frame_err, link_lost} !== 3'b001) begin bad++; $display("FAIL cr_flags got=%b exp=001", {frame_valid, frame_err, link_lost}); end
    cr = 1'b1;
    scan(10, 20, 30, 3, 5);
    scan(21, 43, 5, 0, 5);
    repeat (4) @(negedge clk_50m);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL cr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL cr_evt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    total++; if ({hour, minute, second} !== 24'h214305) begin bad++; $display("FAIL cr_frame_time got=%h exp=214305", {hour, minute, second}); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      int kind, h, m, sc, k;
      kind = int'($urandom_range(0, 3));
      h    = int'($urandom_range(0, 23));
      m    = int'($urandom_range(0, 59));
      sc   = int'($urandom_range(0, 59));
      k    = int'($urandom_range(0, 5));
      case (kind)
        0: scan(h, m, sc, 0, 5);
        1: scan(int'($urandom_range(0, 99)), int'($urandom_range(0, 99)), int'($urandom_range(0, 99)), 0, 5);
        2: begin
          scan(h, m, sc, 0, k - 1);
          show(8'(1 << k), 7'($urandom), int'($urandom_range(8, 16)));
          scan(h, m, sc, k + 1, 5);
        end
        default: begin
          scan(h, m, sc, 0, 2);
          show(8'h02, seg_tab[$urandom_range(0, 9)], int'($urandom_range(8, 16)));
          scan(h, m, sc, 3, 5);
        end
      endcase
    end
    repeat (4) @(negedge clk_50m);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_evt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    total++; if ({hour, minute, second} !== {pub_h, pub_m, pub_s}) begin bad++; $display("FAIL rand_time got=%h exp=%h", {hour, minute, second}, {pub_h, pub_m, pub_s}); end
  endtask

  initial begin
    @(negedge clk_50m);
    test_reset();
    test_scan();
    test_bad_digit();
    test_range();
    test_glitch();
    test_link_lost();
    test_cr_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
